ps2_note_decoder: RTL and testbench
===================================

PS2_NOTE_DECODER -- requirements
Module: ps2_note_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 byte_valid  input  1  one-clk pulse, new PS/2 scan byte available; clk-synchronous.
REQ-005 byte_data  input  8  scan byte (set 2), valid while byte_valid high.
REQ-006 evt_ready  input  1  consumer accepts head event this cycle.
REQ-007 evt_valid  output  1  FIFO non-empty; head event presented.
REQ-008 evt_note  output  5  note index 0..20 of head event.
REQ-009 evt_on  output  1  1 = note-on (make), 0 = note-off (break).
REQ-010 overflow  output  1  sticky; an event was dropped on full FIFO.
REQ-011 held  output  21  bit n = note n currently held (present only with TYPEMATIC_FILTER_EN).

Function
REQ-012 Prefix FSM states IDLE, BRK, EXT, EXT_BRK; transitions only on byte_valid cycles.
REQ-013 IDLE: F0->BRK; E0->EXT; any other byte = make code, evaluate, stay IDLE.
REQ-014 BRK: any byte other than F0/E0 = break code, evaluate, ->IDLE; F0 stays BRK; E0->EXT.
REQ-015 EXT: F0->EXT_BRK; E0 stays EXT; other byte discarded, ->IDLE.
REQ-016 EXT_BRK: any byte discarded, ->IDLE; extended keys never produce events.
REQ-017 Make/break map, scan->note: 1A->0, 1B->1, 22->2, 23->3, 21->4, 2A->5, 34->6, 32->7, 33->8, 31->9, 3B->10, 3A->11, 15->12, 1E->13, 1D->14, 26->15, 24->16, 2D->17, 2E->18, 2C->19, 36->20.
REQ-018 Unmapped code: no event, no state change beyond FSM return to IDLE.
REQ-019 Mapped code pushes {note, on} into FIFO; evt_valid rises the cycle after the completing byte_valid when FIFO was empty (latency 1).
REQ-020 Pop when evt_valid & evt_ready; FIFO order strictly first-in first-out.
REQ-021 evt_note/evt_on stable while evt_valid high and evt_ready low.
REQ-022 Push on full FIFO without simultaneous pop: event dropped, overflow set, held to reset.
REQ-023 Push and pop same cycle: both performed, occupancy unchanged; push accepted even when full.
REQ-024 Pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-025 byte_valid asserted on consecutive cycles: every byte processed, none lost.

Reset
REQ-026 rst low: FSM->IDLE, FIFO empty, evt_valid=0, evt_note=0, evt_on=0, overflow=0, held=0, immediately, clock not required.
REQ-027 Reset mid-sequence (after F0 or E0) discards the partial sequence; first byte after release is decoded from IDLE.
REQ-028 byte_valid during reset ignored; release synchronised before use, no event in first cycle after release.

Configuration
REQ-029 Macro TYPEMATIC_FILTER_EN defined: 21-bit held bitmap kept; make for already-held note and break for non-held note produce no event; accepted make sets bit, accepted break clears bit (bit updates even if event dropped on full FIFO); held port present.
REQ-030 Macro undefined: no bitmap, no held port; every mapped make/break produces an event, including typematic repeats.

Verification
REQ-031 Bytes 1A, then F0 1A, evt_ready=1 -> events {0,on} then {0,off}; evt_valid one cycle after each completing byte.
REQ-032 evt_ready=0, six make codes 1A 1B 22 23 21 2A (filter on) -> FIFO holds notes 0..3, overflow=1; then ready=1 drains 0,1,2,3 in order.
REQ-033 E0 1A, E0 F0 1A, 5A, F0 5A -> no events, FSM IDLE, overflow=0.
REQ-034 Filter on: 15 15 15 F0 15 -> one {12,on}, one {12,off}; held[12] 1 then 0. Filter off: three {12,on} then {12,off}.
REQ-035 Send F0, assert rst low two cycles mid-sequence, release, send 1A -> single {0,on}, all outputs 0 during reset.
REQ-036 FIFO full, evt_ready=1 and new make 3A same cycle -> head popped, {11,on} enqueued, overflow stays 0.

Source files
------------

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-byte decoder turning piano-row keys into note on/off events
// queued in a small FIFO.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset, release synchronised internally
//   byte_valid  one-cycle strobe, byte_data holds a new scan byte
//   byte_data   PS/2 set-2 scan byte
//   evt_ready   consumer takes the head event this cycle
//   evt_valid   FIFO non-empty, head event on evt_note/evt_on
//   evt_note    note index 0..20 of head event
//   evt_on      1 = note-on (make), 0 = note-off (break)
//   overflow    sticky, an event was dropped on a full FIFO
//   held        per-note held bitmap (TYPEMATIC_FILTER_EN only)
//
// Build option: define TYPEMATIC_FILTER_EN to suppress typematic repeats
// and orphan breaks using a held-note bitmap, and to expose the held port.
module ps2_note_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [4:0] evt_note,
    output logic       evt_on,
    output logic       overflow
`ifdef TYPEMATIC_FILTER_EN
    ,
    output logic [20:0] held
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_sync;
    logic        w_byte;
    logic        w_eval;
    logic        w_is_brk;
    logic [5:0]  w_map;
    logic        w_hit;
    logic [4:0]  w_note;
    logic        w_push;
    logic        w_full;
    logic        w_pop;
    logic        w_wr;
    logic [5:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic        r_ovf;

    // {hit, note}; hit=0 for codes outside the piano rows
    function automatic logic [5:0] f_map(input logic [7:0] b);
        case (b)
            8'h1A:   f_map = {1'b1, 5'd0};
            8'h1B:   f_map = {1'b1, 5'd1};
            8'h22:   f_map = {1'b1, 5'd2};
            8'h23:   f_map = {1'b1, 5'd3};
            8'h21:   f_map = {1'b1, 5'd4};
            8'h2A:   f_map = {1'b1, 5'd5};
            8'h34:   f_map = {1'b1, 5'd6};
            8'h32:   f_map = {1'b1, 5'd7};
            8'h33:   f_map = {1'b1, 5'd8};
            8'h31:   f_map = {1'b1, 5'd9};
            8'h3B:   f_map = {1'b1, 5'd10};
            8'h3A:   f_map = {1'b1, 5'd11};
            8'h15:   f_map = {1'b1, 5'd12};
            8'h1E:   f_map = {1'b1, 5'd13};
            8'h1D:   f_map = {1'b1, 5'd14};
            8'h26:   f_map = {1'b1, 5'd15};
            8'h24:   f_map = {1'b1, 5'd16};
            8'h2D:   f_map = {1'b1, 5'd17};
            8'h2E:   f_map = {1'b1, 5'd18};
            8'h2C:   f_map = {1'b1, 5'd19};
            8'h36:   f_map = {1'b1, 5'd20};
            default: f_map = 6'd0;
        endcase
    endfunction

    // Reset asserts at once but releases two edges late, so a byte
    // arriving right at release is never decoded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= 2'b00;
        else      r_sync <= {r_sync[0], 1'b1};
    end

    assign w_byte = byte_valid & r_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        w_is_brk    = 1'b0;
        if (w_byte) begin
            unique case (r_state)
                IDLE: begin
                    if (byte_data == 8'hF0)      w_state_nxt = BRK;
                    else if (byte_data == 8'hE0) w_state_nxt = EXT;
                    else                         w_eval = 1'b1;
                end
                BRK: begin
                    if (byte_data == 8'hF0)      w_state_nxt = BRK;
                    else if (byte_data == 8'hE0) w_state_nxt = EXT;
                    else begin
                        w_eval      = 1'b1;
                        w_is_brk    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                EXT: begin
                    if (byte_data == 8'hF0)      w_state_nxt = EXT_BRK;
                    else if (byte_data == 8'hE0) w_state_nxt = EXT;
                    else                         w_state_nxt = IDLE;
                end
                EXT_BRK: w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_map  = f_map(byte_data);
    assign w_hit  = w_eval & w_map[5];
    assign w_note = w_map[4:0];

`ifdef TYPEMATIC_FILTER_EN
    logic [20:0] r_held;
    logic [20:0] w_onehot;
    logic        w_cur;

    assign w_onehot = 21'(1) << w_note;
    assign w_cur    = |(r_held & w_onehot);
    // only state changes of a key become events
    assign w_push   = w_hit & (w_is_brk ? w_cur : ~w_cur);
    assign held     = r_held;

    // bitmap tracks the keyboard even when the event itself is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_held <= '0;
        end else if (w_hit) begin
            if (w_is_brk) r_held <= r_held & ~w_onehot;
            else          r_held <= r_held | w_onehot;
        end
    end
`else
    assign w_push = w_hit;
`endif

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = evt_valid & evt_ready;
    // a simultaneous pop frees the slot, so full does not block the push
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= {w_note, ~w_is_brk};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_wr & ~w_pop)      r_count <= r_count + CW'(1);
            else if (~w_wr & w_pop) r_count <= r_count - CW'(1);
            if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
        end
    end

    assign evt_valid = (r_count != '0);
    // head gated by valid so outputs read zero when empty or in reset
    assign {evt_note, evt_on} = evt_valid ? r_mem[r_rd] : 6'd0;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Self-checking bench for ps2_note_decoder: directed scenarios plus
// random byte streams compared against a queue-based reference model.
module tb_ps2_note_decoder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       evt_ready;
    logic       evt_valid;
    logic [4:0] evt_note;
    logic       evt_on;
    logic       overflow;
`ifdef TYPEMATIC_FILTER_EN
    logic [20:0] held;
`endif

    ps2_note_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_note   (evt_note),
        .evt_on     (evt_on),
        .overflow   (overflow)
`ifdef TYPEMATIC_FILTER_EN
        ,
        .held       (held)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [5:0]  m_q[$];
    bit          m_ovf;
    bit          m_ext;
    bit          m_brk;
    bit [20:0]   m_held;

    byte unsigned keys [21] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
                                8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
                                8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D,
                                8'h2E, 8'h2C, 8'h36};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 21; i++)
            if (keys[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 0;
        m_ext  = 0;
        m_brk  = 0;
        m_held = '0;
    endtask

    // advance the model by one clock using the inputs currently driven
    task automatic model_edge();
        bit         pop;
        bit         full;
        bit         ev;
        bit         make;
        int         n;
        logic [5:0] e;
        pop  = (m_q.size() != 0) && evt_ready;
        full = (m_q.size() == DEPTH);
        ev   = 0;
        e    = '0;
        if (byte_valid) begin
            if (m_ext && m_brk) begin
                m_ext = 0;
                m_brk = 0;
            end else if (byte_data == 8'hF0) begin
                m_brk = 1;
            end else if (byte_data == 8'hE0) begin
                m_ext = 1;
                m_brk = 0;
            end else begin
                n = note_of(byte_data);
                if (!m_ext && n >= 0) begin
                    make = !m_brk;
                    ev   = 1;
`ifdef TYPEMATIC_FILTER_EN
                    if (make == m_held[n]) ev = 0;
                    m_held[n] = make;
`endif
                    e = {n[4:0], make};
                end
                m_ext = 0;
                m_brk = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (ev) begin
            if (!full || pop) m_q.push_back(e);
            else              m_ovf = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("valid", 32'(evt_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("note", 32'(evt_note), 32'(m_q[0][5:1]));
            chk("on", 32'(evt_on), 32'(m_q[0][0]));
        end
        chk("ovf", 32'(overflow), 32'(m_ovf));
`ifdef TYPEMATIC_FILTER_EN
        chk("held", 32'(held), 32'(m_held));
`endif
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
        chk({tag, "_note"}, 32'(evt_note), 32'd0);
        chk({tag, "_on"}, 32'(evt_on), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
`ifdef TYPEMATIC_FILTER_EN
        chk({tag, "_held"}, 32'(held), 32'd0);
`endif
    endtask

    // reset asserted mid-cycle with a byte strobe held active throughout
    task automatic do_reset(input int n);
        rst        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h1A;
        #1;
        chk_zero("rst_async");
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_zero("rst_hold");
            @(posedge clk);
            #1;
        end
        rst        = 1'b1;
        byte_valid = 1'b0;
        idle(3);
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        evt_ready  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // make then break with consumer always ready
        evt_ready = 1'b1;
        send(8'h1A);
        chk("lat_make", 32'(evt_valid), 32'd1);
        send(8'hF0);
        send(8'h1A);
        chk("lat_brk", 32'(evt_valid), 32'd1);
        idle(3);

        // back-to-back makes into a stalled FIFO
        evt_ready = 1'b0;
        send(8'h1A); send(8'h1B); send(8'h22);
        send(8'h23); send(8'h21); send(8'h2A);
        idle(2);
        chk("ovf_full", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        idle(6);
        do_reset(1);

        // extended and unmapped codes produce nothing
        send(8'hE0); send(8'h1A);
        send(8'hE0); send(8'hF0); send(8'h1A);
        send(8'h5A);
        send(8'hF0); send(8'h5A);
        idle(2);
        chk("ext_none", 32'(evt_valid), 32'd0);

        // typematic repeats
        evt_ready = 1'b0;
        send(8'h15); send(8'h15); send(8'h15);
        send(8'hF0); send(8'h15);
        idle(2);
        evt_ready = 1'b1;
        idle(6);

        // reset in the middle of a break prefix
        send(8'hF0);
        do_reset(2);
        send(8'h1A);
        chk("post_rst_on", 32'(evt_on), 32'd1);
        idle(3);
        do_reset(1);

        // full FIFO with simultaneous pop and push
        evt_ready = 1'b0;
        send(8'h1A); send(8'h1B); send(8'h22); send(8'h23);
        idle(1);
        evt_ready = 1'b1;
        send(8'h3A);
        evt_ready = 1'b0;
        idle(1);
        chk("sim_ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        idle(6);

        // random streams
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i % 750 == 749) do_reset(1 + $urandom_range(0, 2));
            evt_ready  = ($urandom_range(0, 99) < 45);
            byte_valid = ($urandom_range(0, 99) < 60);
            r = $urandom_range(0, 31);
            if (r < 21)       byte_data = keys[r];
            else if (r < 25)  byte_data = 8'hF0;
            else if (r < 28)  byte_data = 8'hE0;
            else if (r == 28) byte_data = 8'h5A;
            else if (r == 29) byte_data = 8'h6B;
            else              byte_data = 8'($urandom);
            step();
        end
        byte_valid = 1'b0;
        evt_ready  = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
